// File: rtl/relu_seq_ctrl_pkg.sv
// Shared constants for the ReLU sequencing controller.
// Holds the FSM state encodings and the output FIFO depth.
package relu_seq_ctrl_pkg;

  // state    | meaning
  // ST_IDLE  | waiting for start, no job active
  // ST_RUN   | issuing feature-memory reads
  // ST_DRAIN | all reads issued, emptying the FIFO
  // ST_DONE  | one-cycle completion pulse
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/relu_seq_ctrl_relu.sv
// ReLU activation cell: clamps a signed element to a floor value.
// Ports:
//   data_i - signed input element
//   data_o - data_i if above THRESHOLD, otherwise THRESHOLD
module relu_seq_ctrl_relu #(
  parameter int BITWIDTH  = 8,
  parameter int THRESHOLD = 0
) (
  input  logic signed [BITWIDTH-1:0] data_i,
  output logic signed [BITWIDTH-1:0] data_o
);

  localparam logic signed [BITWIDTH-1:0] THR = BITWIDTH'(THRESHOLD);

  assign data_o = (data_i > THR) ? data_i : THR;

endmodule

// File: rtl/relu_seq_ctrl.sv
// ReLU sequencing controller: reads len elements starting at base_addr from a
// feature memory (one-cycle read latency), passes them through the ReLU cell
// and streams them out over a valid/ready interface via a 2-entry FIFO.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, base_addr,   - job request (accepted only in IDLE)
//   len
//   rd_en, rd_addr,     - feature-memory read port
//   rd_data
//   out_valid,          - activated output stream
//   out_ready, out_data
//   busy, done          - status: busy outside IDLE, done pulses on completion
module relu_seq_ctrl #(
  parameter int BITWIDTH  = 8,
  parameter int THRESHOLD = 0,
  parameter int ADDR_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [ADDR_W-1:0]          len,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          rd_addr,
  input  logic signed [BITWIDTH-1:0] rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out_data,
  output logic                       busy,
  output logic                       done
);
  import relu_seq_ctrl_pkg::*;

  logic [1:0]                 state_q, state_d;
  logic [ADDR_W-1:0]          base_q, base_d;
  logic [ADDR_W-1:0]          len_q, len_d;
  logic [ADDR_W-1:0]          issued_q, issued_d;
  logic                       inflight_q;
  logic [1:0]                 cnt_q, cnt_d;
  logic signed [BITWIDTH-1:0] mem0_q, mem0_d;
  logic signed [BITWIDTH-1:0] mem1_q, mem1_d;
  logic signed [BITWIDTH-1:0] act;
  logic                       pop;
  logic [2:0]                 occ_ahead;

  relu_seq_ctrl_relu #(
    .BITWIDTH (BITWIDTH),
    .THRESHOLD(THRESHOLD)
  ) u_relu (
    .data_i(rd_data),
    .data_o(act)
  );

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem0_q;
  assign pop       = out_valid & out_ready;

  // FIFO occupancy after this cycle's pop, counting the read whose data lands
  // next edge; a new read is only issued if its data is guaranteed a slot.
  assign occ_ahead = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (state_q == ST_RUN) && (occ_ahead < 3'(FIFO_DEPTH));
  assign rd_addr   = base_q + issued_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          state_d  = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          issued_d = issued_q + ADDR_W'(1);
          if (issued_q + ADDR_W'(1) == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing in flight and the last stored element leaves this cycle.
        if (!inflight_q && occ_ahead == 3'd0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry 0 is the head and drives out_data directly; entry 1 only holds
  // the second element while the head is stalled.
  always_comb begin
    cnt_d  = cnt_q;
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    case (cnt_q)
      2'd0: begin
        if (inflight_q) begin
          mem0_d = act;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (inflight_q && pop) begin
          mem0_d = act;
        end else if (inflight_q) begin
          mem1_d = act;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          mem0_d = mem1_q;
          if (inflight_q) mem1_d = act;
          else            cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      mem0_q     <= '0;
      mem1_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= rd_en;
      cnt_q      <= cnt_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
    end
  end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
module tb_relu_seq_ctrl;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [9:0] base_addr, len;
  logic rd_en0, rd_en2, out_valid0, out_valid2, busy0, busy2, done0, done2;
  logic [9:0] rd_addr0, rd_addr2;
  logic signed [7:0] rd_q, out_data0, out_data2;

  logic signed [7:0] mem [1024];
  int exp0_q[$];
  int exp2_q[$];
  int addr_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int occ = 0;
  int rd_count = 0;
  int hs0 = 0;
  int done_count = 0;
  logic held_v0 = 1'b0, held_v2 = 1'b0;
  logic signed [7:0] held_d0, held_d2;

  always #5 clk = ~clk;

  relu_seq_ctrl #(.BITWIDTH(8), .THRESHOLD(0), .ADDR_W(10)) dut0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_q),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .busy(busy0), .done(done0));

  relu_seq_ctrl #(.BITWIDTH(8), .THRESHOLD(2), .ADDR_W(10)) dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_q),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .busy(busy2), .done(done2));

  // Feature memory with one-cycle read latency.
  always @(posedge clk) if (rd_en0) rd_q <= mem[rd_addr0];

  function automatic int relu(int v, int t);
    return (v > t) ? v : t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(int b, int l);
    for (int i = 0; i < l; i++) begin
      int a;
      a = (b + i) % 1024;
      addr_q.push_back(a);
      exp0_q.push_back(relu(int'(mem[a]), 0));
      exp2_q.push_back(relu(int'(mem[a]), 2));
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en0) begin
        rd_count++;
        if (addr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_addr", int'(rd_addr0), addr_q.pop_front());
        chk("rd_addr_dut2", int'(rd_addr2), int'(rd_addr0));
      end
      if (busy0) chk("fifo_occ_le2", int'(occ > 2), 0);
      if (held_v0) begin
        chk("stall_valid", int'(out_valid0), 1);
        chk("stall_hold", int'(out_data0), int'(held_d0));
      end
      if (held_v2) chk("stall_hold_t2", int'(out_data2), int'(held_d2));
      if (out_valid0 && out_ready) begin
        hs0++;
        if (exp0_q.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_data", int'(out_data0), exp0_q.pop_front());
      end
      if (out_valid2 && out_ready) begin
        if (exp2_q.size() == 0) chk("out_unexpected_t2", 1, 0);
        else chk("out_data_t2", int'(out_data2), exp2_q.pop_front());
      end
      occ = occ + int'(rd_en0) - int'(out_valid0 && out_ready);
      held_v0 = out_valid0 && !out_ready;
      held_d0 = out_data0;
      held_v2 = out_valid2 && !out_ready;
      held_d2 = out_data2;
      if (done0) done_count++;
    end
  end

  task automatic chk_quiet(string nm);
    chk({nm, "_rd_en"}, int'(rd_en0), 0);
    chk({nm, "_out_valid"}, int'(out_valid0), 0);
    chk({nm, "_out_data"}, int'(out_data0), 0);
    chk({nm, "_busy"}, int'(busy0), 0);
    chk({nm, "_done"}, int'(done0), 0);
    chk({nm, "_out_data_t2"}, int'(out_data2), 0);
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready
  task automatic run_job(int b, int l, int mode, bit inject);
    int h;
    bit seen;
    h = hs0;
    seen = 1'b0;
    push_job(b, l);
    base_addr = 10'(b);
    len = 10'(l);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (done0) begin
        seen = 1'b1;
        break;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (k % 4 == 0) || (k % 4 == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (inject && k == 1) begin
        start = 1'b1;
        base_addr = 10'd0;
        len = 10'd5;
      end
      if (inject && k == 2) start = 1'b0;
      tick();
    end
    chk("done_seen", int'(seen), 1);
    out_ready = 1'b1;
    tick();
    chk("done_one_cycle", int'(done0), 0);
    chk("idle_after_done", int'(busy0), 0);
    chk("handshakes", hs0 - h, l);
    chk("exp_left", exp0_q.size() + exp2_q.size() + addr_q.size(), 0);
  endtask

  initial begin
    int h, dc, rc;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    #2;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Directed timing: base 5, len 4
    mem[5] = -8'sd3; mem[6] = 8'sd7; mem[7] = 8'sd0; mem[8] = -8'sd128;
    push_job(5, 4);
    h = hs0;
    out_ready = 1'b1;
    base_addr = 10'd5;
    len = 10'd4;
    start = 1'b1;
    chk("c0_busy", int'(busy0), 0);
    tick();
    start = 1'b0;
    chk("c1_rd_en", int'(rd_en0), 1);
    chk("c1_busy", int'(busy0), 1);
    tick();
    chk("c2_out_valid", int'(out_valid0), 0);
    tick();
    chk("c3_out_valid", int'(out_valid0), 1);
    repeat (3) tick();
    chk("c6_out_valid", int'(out_valid0), 1);
    chk("c6_done", int'(done0), 0);
    tick();
    chk("c7_done", int'(done0), 1);
    chk("c7_out_valid", int'(out_valid0), 0);
    tick();
    chk("c8_done", int'(done0), 0);
    chk("c8_busy", int'(busy0), 0);
    chk("t1_handshakes", hs0 - h, 4);

    // len == 0
    rc = rd_count;
    len = 10'd0;
    base_addr = 10'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", int'(done0), 1);
    chk("len0_busy", int'(busy0), 1);
    tick();
    chk("len0_done_end", int'(done0), 0);
    chk("len0_busy_end", int'(busy0), 0);
    chk("len0_no_reads", rd_count - rc, 0);

    // Backpressure pattern
    run_job(300, 6, 1, 1'b0);
    // Address wrap
    run_job(1022, 4, 0, 1'b0);

    // Reset mid-RUN after two handshakes
    push_job(100, 8);
    h = hs0;
    dc = done_count;
    base_addr = 10'd100;
    len = 10'd8;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (hs0 - h >= 2) break;
      tick();
    end
    chk("pre_reset_hs", hs0 - h, 2);
    chk("pre_reset_busy", int'(busy0), 1);
    rst = 1'b1;
    #1;
    chk_quiet("midrun_reset");
    exp0_q.delete();
    exp2_q.delete();
    addr_q.delete();
    occ = 0;
    held_v0 = 1'b0;
    held_v2 = 1'b0;
    repeat (3) tick();
    chk_quiet("reset_hold");
    rst = 1'b0;
    tick();
    chk("no_done_on_reset", done_count - dc, 0);
    run_job(40, 5, 0, 1'b0);

    // Threshold cell and ignored start during busy
    mem[200] = 8'sd1; mem[201] = 8'sd2; mem[202] = 8'sd3;
    run_job(200, 3, 0, 1'b1);

    // Random jobs
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      run_job(int'($urandom_range(0, 1023)), int'($urandom_range(1, 12)), 2, 1'(j % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/relu_seq_ctrl.md
RELU_SEQ_CTRL -- requirements
Module: relu_seq_ctrl

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8, meaning the signed element width.
REQ-002 SHALL have parameter THRESHOLD, default 0, meaning the ReLU clamp floor, passed to the activation cell.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning the feature-map address and length width.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit, meaning the asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit, meaning a job request sampled only in IDLE.
REQ-008 SHALL have port base_addr, input, ADDR_W bits, meaning the first read address, latched on an accepted start.
REQ-009 SHALL have port len, input, ADDR_W bits, meaning the element count, latched on an accepted start.
REQ-010 SHALL have port rd_en, output, 1 bit, meaning the feature-memory read strobe.
REQ-011 SHALL have port rd_addr, output, ADDR_W bits, meaning the feature-memory read address.
REQ-012 SHALL have port rd_data, input signed, BITWIDTH bits, meaning read data, valid exactly one cycle after rd_en.
REQ-013 SHALL have port out_valid, output, 1 bit, meaning the output stream valid.
REQ-014 SHALL have port out_ready, input, 1 bit, meaning the output stream ready.
REQ-015 SHALL have port out_data, output signed, BITWIDTH bits, meaning the activated element.
REQ-016 SHALL have port busy, output, 1 bit, meaning high in any state other than IDLE.
REQ-017 SHALL have port done, output, 1 bit, meaning a one-cycle pulse when the job completes.

Function
REQ-018 SHALL implement an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-019 SHALL perform IDLE->RUN on start=1 with len!=0, and IDLE->DONE on start=1 with len==0, issuing no reads in the len==0 case.
REQ-020 SHALL, in RUN, issue rd_en with rd_addr=base_addr+issued_count, where issued_count starts at 0; address arithmetic wraps modulo 2^ADDR_W.
REQ-021 SHALL assert rd_en only when fifo_count + inflight - pop < 2, where inflight=rd_en of the previous cycle and pop=out_valid&out_ready.
REQ-022 SHALL write rd_data through the ReLU cell (result = data>THRESHOLD ? data : THRESHOLD) into a 2-entry FIFO in the cycle rd_data is valid.
REQ-023 SHALL drive out_valid and out_data from the FIFO head, registered; the first out_valid appears in cycle 3 when start is sampled in cycle 0.
REQ-024 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain 1 element/cycle with out_ready held high.
REQ-026 SHALL allow the FIFO to accept a write and perform a pop in the same cycle, leaving the count unchanged.
REQ-027 SHALL perform RUN->DRAIN when issued_count reaches len.
REQ-028 SHALL perform DRAIN->DONE when the FIFO is empty, inflight=0, and the final pop occurs.
REQ-029 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL emit exactly len output handshakes per job, in address order.

Reset
REQ-032 SHALL, on rst=1, immediately clear the FSM to IDLE, clear counters, and flush the FIFO.
REQ-033 SHALL drive rd_en=0, out_valid=0, out_data=0, busy=0 and done=0 while rst=1.
REQ-034 SHALL abandon any job in progress when reset is asserted, with no done pulse; the read data of an in-flight read is discarded.

Structure
REQ-035 SHALL place the FSM state encodings and the FIFO depth constant (2) in the shared CNN package.
REQ-036 SHALL instantiate the existing Relu module as its sole sub-module, with BITWIDTH and THRESHOLD passed through.

Verification
REQ-037 SHALL cover: base_addr=5, len=4, out_ready=1, mem[5..8]={-3,7,0,-128} -> out_data 0,7,0,0 in cycles 3-6, done in cycle 7.
REQ-038 SHALL cover: len=0 -> no rd_en, done one cycle after start, busy high for exactly 1 cycle.
REQ-039 SHALL cover: len=6, out_ready toggling 1,0,0,1,... -> no loss or duplication, FIFO count never exceeds 2, out_data stable while stalled.
REQ-040 SHALL cover: base_addr=1022, len=4 -> rd_addr sequence 1022,1023,0,1.
REQ-041 SHALL cover: rst asserted mid-RUN after 2 handshakes -> outputs 0 immediately, no done pulse; a new start then completes normally.
REQ-042 SHALL cover: THRESHOLD=2, inputs {1,2,3} -> outputs {2,2,3}; a start pulse during busy is ignored.
